fir_l3_block_serializer: RTL and testbench

- Downstream stage of the L=3 reduced-complexity parallel FIR.
- Captures each 3-sample output block (lanes y(3k), y(3k+1), y(3k+2)) in a small register FIFO.
- Scales each sample down to a narrower output width.
- Emits the samples one per accepted handshake on a serial valid/ready stream, so the block-rate filter can feed a sample-rate consumer such as a DAC or stream sink.

---
 rtl/fir_l3_block_serializer.sv | 154 +++++++++++++++
 tb/tb_fir_l3_block_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fir_l3_block_serializer.sv
// Serializes 3-lane FIR output blocks into a scaled sample stream through a small block FIFO.
// Build option: define FIR_L3_SER_SAT_EN to saturate scaled samples instead of wrapping them.
module fir_l3_block_serializer #(
   parameter int DATA_IN_WIDTH  = 64,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int SHIFT          = 30,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  in_valid,
   input  logic signed [DATA_IN_WIDTH-1:0]       lane_1,
   input  logic signed [DATA_IN_WIDTH-1:0]       lane_2,
   input  logic signed [DATA_IN_WIDTH-1:0]       lane_3,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic signed [DATA_OUT_WIDTH-1:0]      out_data,
   output logic [$clog2(FIFO_DEPTH):0]           fill_level,
   output logic                                  overflow,
   input  logic                                  clr_ovf
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [FILL_W-1:0] FILL_ONE   = {{(FILL_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {L0 = 2'd0, L1 = 2'd1, L2 = 2'd2} lane_t;

`ifdef FIR_L3_SER_SAT_EN
   localparam logic signed [DATA_IN_WIDTH-1:0] SAT_MAX =
      {{(DATA_IN_WIDTH-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_IN_WIDTH-1:0] SAT_MIN =
      {{(DATA_IN_WIDTH-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

   function automatic logic signed [DATA_OUT_WIDTH-1:0] scale(input logic signed [DATA_IN_WIDTH-1:0] x);
      logic signed [DATA_IN_WIDTH-1:0] t;
      t = x >>> SHIFT;
      if (t > SAT_MAX)
         return SAT_MAX[DATA_OUT_WIDTH-1:0];
      else if (t < SAT_MIN)
         return SAT_MIN[DATA_OUT_WIDTH-1:0];
      else
         return t[DATA_OUT_WIDTH-1:0];
   endfunction
`else
   function automatic logic signed [DATA_OUT_WIDTH-1:0] scale(input logic signed [DATA_IN_WIDTH-1:0] x);
      return DATA_OUT_WIDTH'(x >>> SHIFT);
   endfunction
`endif

   logic signed [DATA_IN_WIDTH-1:0] mem_1_r [FIFO_DEPTH];
   logic signed [DATA_IN_WIDTH-1:0] mem_2_r [FIFO_DEPTH];
   logic signed [DATA_IN_WIDTH-1:0] mem_3_r [FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr_r;
   logic [PTR_W-1:0]                rd_ptr_r;
   logic [FILL_W-1:0]               fill_r;
   logic [FILL_W-1:0]               fill_next_s;
   logic                            valid_r;
   logic                            ovf_r;
   lane_t                           lane_r;
   logic                            full_s;
   logic                            xfer_s;
   logic                            pop_s;
   logic                            push_s;
   logic signed [DATA_IN_WIDTH-1:0] head_s;

   assign full_s     = (fill_r == DEPTH_FILL);
   assign xfer_s     = valid_r && out_ready;
   assign pop_s      = xfer_s && (lane_r == L2);
   // A pop frees the slot in the same edge, so a full FIFO still accepts a block then.
   assign push_s     = in_valid && (!full_s || pop_s);
   assign out_valid  = valid_r;
   assign fill_level = fill_r;
   assign overflow   = ovf_r;

   // Next occupancy from push/pop combination.
   always_comb begin
      fill_next_s = fill_r;
      if (push_s && !pop_s)
         fill_next_s = fill_r + FILL_ONE;
      else if (pop_s && !push_s)
         fill_next_s = fill_r - FILL_ONE;
      else
         fill_next_s = fill_r;
   end

   // Block storage and write pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_1_r[i] <= '0;
            mem_2_r[i] <= '0;
            mem_3_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else if (push_s) begin
         mem_1_r[wr_ptr_r] <= lane_1;
         mem_2_r[wr_ptr_r] <= lane_2;
         mem_3_r[wr_ptr_r] <= lane_3;
         wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end
   end

   // Occupancy, valid flag, read pointer and sticky overflow (set beats clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_r   <= '0;
         valid_r  <= 1'b0;
         rd_ptr_r <= '0;
         ovf_r    <= 1'b0;
      end else begin
         fill_r  <= fill_next_s;
         valid_r <= (fill_next_s != '0);
         if (pop_s)
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (in_valid && full_s && !pop_s)
            ovf_r <= 1'b1;
         else if (clr_ovf)
            ovf_r <= 1'b0;
      end
   end

   // Lane pointer FSM: advances on each accepted sample only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_r <= L0;
      end else if (xfer_s) begin
         case (lane_r)
            L0:      lane_r <= L1;
            L1:      lane_r <= L2;
            L2:      lane_r <= L0;
            default: lane_r <= L0;
         endcase
      end
   end

   // Head-entry lane mux and scaling; output is zero while idle.
   always_comb begin
      head_s = mem_1_r[rd_ptr_r];
      case (lane_r)
         L0:      head_s = mem_1_r[rd_ptr_r];
         L1:      head_s = mem_2_r[rd_ptr_r];
         L2:      head_s = mem_3_r[rd_ptr_r];
         default: head_s = mem_1_r[rd_ptr_r];
      endcase
      if (valid_r)
         out_data = scale(head_s);
      else
         out_data = '0;
   end

endmodule

// File: tb/tb_fir_l3_block_serializer.sv
// Scoreboard bench for fir_l3_block_serializer (default parameters, SHIFT=30).
module tb_fir_l3_block_serializer;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic signed [63:0] lane_1, lane_2, lane_3;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic [2:0]         fill_level;
   logic               overflow;
   logic               clr_ovf;

   int checks = 0;
   int errors = 0;
   logic signed [15:0] exp_q[$];

`ifdef FIR_L3_SER_SAT_EN
   localparam int BIG_POS = 32767;
   localparam int BIG_NEG = -32768;
   localparam int MID_POS = 32767;
`else
   localparam int BIG_POS = 0;
   localparam int BIG_NEG = 0;
   localparam int MID_POS = -32761;
`endif

   fir_l3_block_serializer dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
      .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fill_level(fill_level), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   function automatic logic signed [63:0] s30(input longint v);
      return 64'(v) <<< 30;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens at the next rising edge, compare against the scoreboard.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got %0d expected none", out_data);
         end else begin
            chk("sample", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send_block(input logic signed [63:0] a, b, c,
                             input int ea, eb, ec, input bit accept);
      lane_1 = a; lane_2 = b; lane_3 = c;
      in_valid = 1'b1;
      if (accept) begin
         exp_q.push_back(16'(ea));
         exp_q.push_back(16'(eb));
         exp_q.push_back(16'(ec));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while ((fill_level != 3'd0 || exp_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_drain_timeout"}, n < 200, 1);
      chk({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      lane_1 = '0; lane_2 = '0; lane_3 = '0;
      #22;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Basic order
      out_ready = 1'b1;
      send_block(s30(5), s30(-7), s30(9), 5, -7, 9, 1'b1);
      chk("basic_fill1", fill_level, 1);
      chk("basic_valid1", out_valid, 1);
      repeat (3) begin @(posedge clk); #1; end
      chk("basic_fill0", fill_level, 0);
      chk("basic_valid0", out_valid, 0);
      chk("idle_data0", out_data, 0);

      // Backpressure
      out_ready = 1'b0;
      send_block(s30(1), s30(2), s30(3), 1, 2, 3, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty("bp");

      // Scaling and truncation toward minus infinity
      send_block(64'sh0004_0000_0000_0000, 64'shFFFF_FFFF_4000_0000, -64'sd1,
                 BIG_POS, -3, -1, 1'b1);
      send_block(-64'sh0004_0000_0000_0000, s30(5) + 64'sd536870912, -s30(5) - 64'sd1,
                 BIG_NEG, 5, -6, 1'b1);
      send_block(s30(32775), 64'sd0, s30(1), MID_POS, 0, 1, 1'b1);
      wait_empty("scale");

      // Overflow with FIFO full, set beats clear
      out_ready = 1'b0;
      for (int b = 1; b <= 4; b++)
         send_block(s30(b*10+1), s30(b*10+2), s30(b*10+3), b*10+1, b*10+2, b*10+3, 1'b1);
      chk("full_fill", fill_level, 4);
      chk("full_ovf0", overflow, 0);
      send_block(s30(51), s30(52), s30(53), 51, 52, 53, 1'b0);
      chk("ovf_fill", fill_level, 4);
      chk("ovf_set", overflow, 1);
      clr_ovf = 1'b1;
      send_block(s30(71), s30(72), s30(73), 71, 72, 73, 1'b0);
      clr_ovf = 1'b0;
      chk("ovf_set_wins", overflow, 1);
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      chk("ovf_clr", overflow, 0);

      // Full with simultaneous pop
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      send_block(s30(61), s30(62), s30(63), 61, 62, 63, 1'b1);
      chk("pop_push_fill", fill_level, 4);
      chk("pop_push_ovf", overflow, 0);
      wait_empty("full_pop");

      // Reset mid-operation discards stored blocks
      out_ready = 1'b0;
      send_block(s30(7), s30(8), s30(9), 7, 8, 9, 1'b1);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_fill", fill_level, 0);
      chk("mid_rst_valid", out_valid, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_data", out_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
